prog_loader: RTL and testbench

- Upstream boot stage for the multicycle MIPS core. It receives a program image as a byte stream over a valid/ready handshake and writes it word-by-word into the shared 256-byte memory.
- Holds the core in reset until the image is complete.
- Sits between the external byte source and the memory write port, which it muxes ahead of the core's IorD address path while `cpu_hold` is high.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream boot loader writing a word image into memory while holding the core.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [6:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, next_state, after_last;
  logic [1:0]  byte_cnt;
  logic [6:0]  idx;
  logic [31:0] count;
  logic [31:0] word;
  logic        ready_q;
  logic        take;
  logic [31:0] count_next;
  logic [31:0] word_next;
  logic [6:0]  idx_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign take       = byte_valid && ready_q;
  assign count_next = {count[23:0], byte_in};
  assign word_next  = {word[23:0], byte_in};
  assign idx_inc    = idx + 7'd1;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign after_last = S_CHK;
`else
  assign after_last = S_DONE;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_HDR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HDR: begin
        if (take && byte_cnt == 2'd3) begin
          if (count_next > 32'(MAX_WORDS)) next_state = S_ERR;
          else if (count_next == 32'd0)    next_state = after_last;
          else                             next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (take && byte_cnt == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        if ({25'd0, idx_inc} == count) next_state = after_last;
        else                           next_state = S_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (take) next_state = (byte_in == csum) ? S_DONE : S_ERR;
      end
`endif
      default: next_state = state;
    endcase
  end

  // Ready tracks the state it will be in, so it is already low in the WRITE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      byte_cnt  <= 2'd0;
      idx       <= 7'd0;
      count     <= 32'd0;
      word      <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      ready_q <= (next_state == S_HDR) || (next_state == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                 || (next_state == S_CHK)
`endif
                 ;
      if (take && (state == S_HDR || state == S_DATA)) byte_cnt <= byte_cnt + 2'd1;
      if (take && state == S_HDR) count <= count_next;
      if (take && state == S_DATA) begin
        word <= word_next;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_in;
`endif
        if (byte_cnt == 2'd3) begin
          mem_addr  <= BASE_ADDR + {23'd0, idx, 2'b00};
          mem_wdata <= word_next;
        end
      end
      if (state == S_WRITE) idx <= idx_inc;
    end
  end

  assign byte_ready   = ready_q;
  assign mem_write    = (state == S_WRITE);
  assign cpu_hold     = (state != S_DONE);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign words_loaded = idx;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven image loads with a write scoreboard plus reset/gap/empty-image sequences.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
  } vec_t;
  vec_t vecs[$];

  prog_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && mem_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hFFFFFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] w0, input logic [31:0] w1, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return {b, ~b, 8'(i * 3), 8'hA5};
  endfunction

  task automatic push_write(input int i, input logic [31:0] w);
    wr_t e;
    e.addr = 32'd0 + 32'(4 * i);
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clock);
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("end_timeout", 32'(done || error), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] cs;
`endif

    vecs.push_back('{2,  32'h8C010004, 32'h00000000, 1'b0, 1'b1, 1'b0, 2});
    vecs.push_back('{1,  32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{0,  32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 0});
    vecs.push_back('{65, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 0});
    vecs.push_back('{64, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 64});
    vecs.push_back('{5,  32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 5});
`ifdef PROG_LOADER_CHECKSUM_EN
    vecs.push_back('{1,  32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1, 1});
`endif

    for (int v = 0; v < vecs.size(); v++) begin
      apply_reset();
      send_word(32'(vecs[v].n));
      if (vecs[v].n > 64) begin
        check("hdr_err_next_cycle", 32'(error), 32'd1);
        check("hdr_err_ready", 32'(byte_ready), 32'd0);
        check("hdr_err_hold", 32'(cpu_hold), 32'd1);
        @(negedge clock);
        byte_in = 8'h55;
        byte_valid = 1'b1;
        repeat (5) @(negedge clock);
        byte_valid = 1'b0;
      end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
        cs = 8'd0;
`endif
        for (int i = 0; i < vecs[v].n; i++) begin
          w = word_of(vecs[v].w0, vecs[v].w1, i);
          push_write(i, w);
          send_word(w);
`ifdef PROG_LOADER_CHECKSUM_EN
          cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(vecs[v].bad ? ~cs : cs);
`endif
        wait_end();
      end
      @(negedge clock);
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 32'(error), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
      check($sformatf("v%0d_words", v), 32'(words_loaded), 32'(vecs[v].exp_words));
      check($sformatf("v%0d_ready", v), 32'(byte_ready), 32'd0);
      check($sformatf("v%0d_queue", v), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    // N=1 with valid pattern 1,0,0,1,0,1,1 across the data bytes
    apply_reset();
    send_word(32'd1);
    push_write(0, 32'hCAFE0123);
    send_byte(8'hCA);
    repeat (2) @(posedge clock);
    send_byte(8'hFE);
    @(posedge clock);
    check("gap_no_early_write", 32'(words_loaded), 32'd0);
    send_byte(8'h01);
    send_byte(8'h23);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hCA ^ 8'hFE ^ 8'h01 ^ 8'h23);
`endif
    wait_end();
    @(negedge clock);
    check("gap_done", 32'(done), 32'd1);
    check("gap_words", 32'(words_loaded), 32'd1);
    check("gap_queue", 32'(exp_q.size()), 32'd0);

    // Async reset in the middle of word index 2 of an N=4 image, then reload
    apply_reset();
    send_word(32'd4);
    push_write(0, 32'h11111111);
    push_write(1, 32'h22222222);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_byte(8'h33);
    send_byte(8'h44);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    send_word(32'd1);
    push_write(0, 32'h0F1E2D3C);
    send_word(32'h0F1E2D3C);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h0F ^ 8'h1E ^ 8'h2D ^ 8'h3C);
`endif
    wait_end();
    @(negedge clock);
    check("reload_done", 32'(done), 32'd1);
    check("reload_words", 32'(words_loaded), 32'd1);
    check("reload_queue", 32'(exp_q.size()), 32'd0);

    // Empty image: completion timing right after the 4th header byte
    apply_reset();
    send_word(32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("n0_done_early", 32'(done), 32'd0);
    check("n0_chk_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h00);
`endif
    check("n0_done_next_cycle", 32'(done), 32'd1);
    check("n0_hold", 32'(cpu_hold), 32'd0);
    check("n0_ready", 32'(byte_ready), 32'd0);
    check("n0_words", 32'(words_loaded), 32'd0);

    repeat (4) @(negedge clock);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
